// File: rtl/and_gate_truth_sweeper.sv
// and_gate_truth_sweeper: drives a 2-input gate through its four input rows.
// Each row is held for DWELL cycles, and the gate output is sampled on the
// row's last cycle. The observed 4-bit truth table is then compared with EXPECT.
// Optional build macro GRAY_ORDER_EN: rows are applied as 00,01,11,10 instead
// of binary order. Result bits stay indexed by {in_A,in_B}.
module and_gate_truth_sweeper #(
  parameter int unsigned DWELL  = 8,
  parameter logic [3:0]  EXPECT = 4'b1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       gate_out,
  output logic       in_A,
  output logic       in_B,
  output logic [1:0] row,
  output logic       busy,
  output logic       done,
  output logic [3:0] result,
  output logic       pass
);

  localparam int unsigned CNT_W = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [1:0] STEP_LAST = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       step, step_d;
  logic [1:0]       row_d;
  logic             busy_d;
  logic             done_d;
  logic [3:0]       result_d;
  logic             pass_d;
  logic             row_end_c;
  logic             last_step_c;

  // Maps the sweep step number to the input row actually applied
  function automatic logic [1:0] step_to_row(input logic [1:0] s);
`ifdef GRAY_ORDER_EN
    return {s[1], s[1] ^ s[0]};
`else
    return s;
`endif
  endfunction

  assign row_end_c   = (state == S_SETTLE) && (cnt == CNT_LAST);
  assign last_step_c = (step == STEP_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:   if (start) state_d = S_SETTLE;
      S_SETTLE: if (row_end_c && last_step_c) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values for counters and registered outputs
  always_comb begin
    cnt_d    = cnt;
    step_d   = step;
    row_d    = row;
    busy_d   = busy;
    done_d   = 1'b0;
    result_d = result;
    pass_d   = pass;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          cnt_d    = '0;
          step_d   = 2'd0;
          row_d    = step_to_row(2'd0);
          busy_d   = 1'b1;
          result_d = 4'b0000;
          pass_d   = 1'b0;
        end
      end
      S_SETTLE: begin
        if (row_end_c) begin
          cnt_d         = '0;
          result_d[row] = gate_out;
          if (last_step_c) begin
            step_d = 2'd0;
            row_d  = 2'd0;
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = (result_d == EXPECT);
          end else begin
            step_d = step + 2'd1;
            row_d  = step_to_row(step + 2'd1);
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Registered datapath and outputs; gate inputs come straight from flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      step   <= 2'd0;
      row    <= 2'd0;
      in_A   <= 1'b0;
      in_B   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 4'b0000;
      pass   <= 1'b0;
    end else begin
      cnt    <= cnt_d;
      step   <= step_d;
      row    <= row_d;
      in_A   <= row_d[1];
      in_B   <= row_d[0];
      busy   <= busy_d;
      done   <= done_d;
      result <= result_d;
      pass   <= pass_d;
    end
  end

endmodule
